// File: rtl/ifu_pkg.sv
// Shared IFU definitions: next-PC select encodings and the default fetch base.
package ifu_pkg;

    localparam logic [31:0] PC_BASE_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JREG   = 2'd3
    } npc_op_e;

endpackage

// File: rtl/ifu_if.sv
// IFU bus: instruction-memory port, ID control inputs and IF/ID outputs.
// exc_adel_d exists only when IFU_ADEL_EXC_EN is defined.
interface ifu_if #(parameter int IM_AW = 11);
    import ifu_pkg::*;

    logic             stall;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_ins;
    npc_op_e          npc_op;
    logic             cmp_true;
    logic [31:0]      rs_data;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      pc8_d;
`ifdef IFU_ADEL_EXC_EN
    logic             exc_adel_d;
`endif

    modport master (
        input  stall, im_ins, npc_op, cmp_true, rs_data,
`ifdef IFU_ADEL_EXC_EN
        output exc_adel_d,
`endif
        output im_addr, instr_d, pc_d, pc8_d
    );

    modport slave (
        output stall, im_ins, npc_op, cmp_true, rs_data,
`ifdef IFU_ADEL_EXC_EN
        input  exc_adel_d,
`endif
        input  im_addr, instr_d, pc_d, pc8_d
    );

endinterface

// File: rtl/ifu_npc.sv
// Combinational next-PC selection; branch and jump targets are formed from
// the instruction currently in ID, so the IF-stage fetch becomes the delay slot.
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_d,
    input  logic [25:0] i_instr_idx,
    input  npc_op_e     i_npc_op,
    input  logic        i_cmp_true,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_npc
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;

    assign w_pc4    = i_pc + 32'd4;
    assign w_br_off = {{14{i_instr_idx[15]}}, i_instr_idx[15:0], 2'b00};
    assign w_br_tgt = i_pc_d + 32'd4 + w_br_off;
    assign w_j_tgt  = {i_pc_d[31:28], i_instr_idx, 2'b00};

    always_comb begin
        o_npc = w_pc4;
        case (i_npc_op)
            NPC_PC4:    o_npc = w_pc4;
            NPC_BRANCH: o_npc = i_cmp_true ? w_br_tgt : w_pc4;
            NPC_JUMP:   o_npc = w_j_tgt;
            NPC_JREG:   o_npc = i_rs_data;
            default:    o_npc = w_pc4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, IF/ID pipeline register and next-PC mux.
// Define IFU_ADEL_EXC_EN to flag misaligned/out-of-range fetches on exc_adel_d.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] PC_BASE = PC_BASE_DEFAULT,
    parameter int          IM_AW   = 11
) (
    input  logic   clk,
    input  logic   reset,
    ifu_if.master  bus
);

    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] w_npc;
    logic [31:0] w_fetch;

    // Offsets below PC_BASE wrap to large values and simply alias in the index.
    assign bus.im_addr = IM_AW'((r_pc - PC_BASE) >> 2);
    assign bus.instr_d = r_instr_d;
    assign bus.pc_d    = r_pc_d;
    assign bus.pc8_d   = r_pc_d + 32'd8;

    ifu_npc u_npc (
        .i_pc        (r_pc),
        .i_pc_d      (r_pc_d),
        .i_instr_idx (r_instr_d[25:0]),
        .i_npc_op    (bus.npc_op),
        .i_cmp_true  (bus.cmp_true),
        .i_rs_data   (bus.rs_data),
        .o_npc       (w_npc)
    );

`ifdef IFU_ADEL_EXC_EN
    logic [31:0] w_hi;
    logic        w_adel;
    logic        r_exc_adel_d;

    // Anything at or above 4*2^IM_AW bytes from the base (or below it) is outside the memory.
    assign w_hi    = (r_pc - PC_BASE) >> (IM_AW + 2);
    assign w_adel  = (r_pc[1:0] != 2'b00) || (w_hi != 32'd0);
    assign w_fetch = w_adel ? 32'd0 : bus.im_ins;
    assign bus.exc_adel_d = r_exc_adel_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exc_adel_d <= 1'b0;
        end else if (!bus.stall) begin
            r_exc_adel_d <= w_adel;
        end
    end
`else
    assign w_fetch = bus.im_ins;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= PC_BASE;
            r_instr_d <= 32'd0;
            r_pc_d    <= PC_BASE;
        end else if (!bus.stall) begin
            r_pc      <= w_npc;
            r_instr_d <= w_fetch;
            r_pc_d    <= r_pc;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Randomized and directed bench for ifu against a behavioural fetch model.
// Build with IFU_ADEL_EXC_EN defined to also cover the address-error output.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] PCB   = 32'h0000_3000;
    localparam int          IM_AW = 11;
    localparam int          DEPTH = 2048;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [31:0] mem [0:DEPTH-1];

    ifu_if #(.IM_AW(IM_AW)) bus ();

    ifu #(.PC_BASE(PCB), .IM_AW(IM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.im_ins = mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: architectural PC, IF/ID instruction and PC, address error.
    logic [31:0] m_pc, m_ins, m_pcd;
    logic        m_exc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_index(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - PCB;
        return int'((off / 4) % DEPTH);
    endfunction

    function automatic logic m_bad(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - PCB;
        return (pc % 4 != 0) || (off >= 4 * DEPTH);
    endfunction

    function automatic logic [31:0] m_next();
        int off;
        case (bus.npc_op)
            NPC_BRANCH: begin
                off = int'($signed(m_ins[15:0]));
                return bus.cmp_true ? m_pcd + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
            end
            NPC_JUMP: return (m_pcd & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) * 4);
            NPC_JREG: return bus.rs_data;
            default:  return m_pc + 32'd4;
        endcase
    endfunction

    task automatic m_reset();
        m_pc  = PCB;
        m_ins = 32'd0;
        m_pcd = PCB;
        m_exc = 1'b0;
    endtask

    task automatic compare_all();
        check("im_addr", 32'(bus.im_addr), 32'(m_index(m_pc)));
        check("instr_d", bus.instr_d, m_ins);
        check("pc_d", bus.pc_d, m_pcd);
        check("pc8_d", bus.pc8_d, m_pcd + 32'd8);
`ifdef IFU_ADEL_EXC_EN
        check("exc_adel_d", 32'(bus.exc_adel_d), 32'(m_exc));
`endif
    endtask

    task automatic tick();
        logic [31:0] n_pc, n_ins, n_pcd;
        logic        n_exc;
        n_pc = m_pc; n_ins = m_ins; n_pcd = m_pcd; n_exc = m_exc;
        if (!reset && !bus.stall) begin
            n_pc  = m_next();
            n_pcd = m_pc;
            n_ins = mem[m_index(m_pc)];
            n_exc = 1'b0;
`ifdef IFU_ADEL_EXC_EN
            n_exc = m_bad(m_pc);
            if (n_exc) n_ins = 32'd0;
`endif
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ins = n_ins; m_pcd = n_pcd; m_exc = n_exc;
        compare_all();
    endtask

    task automatic drive(input npc_op_e op, input logic cmp, input logic [31:0] rs, input logic st);
        bus.npc_op   = op;
        bus.cmp_true = cmp;
        bus.rs_data  = rs;
        bus.stall    = st;
    endtask

    task automatic do_reset();
        drive(NPC_PC4, 1'b0, 32'd0, 1'b0);
        reset = 1'b1;
        #1;
        m_reset();
        compare_all();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[2] = {mem[2][31:16], 16'hFFFE};
        mem[4] = 32'h0800_0C10;
        reset = 1'b1;
        drive(NPC_PC4, 1'b0, 32'd0, 1'b0);

        // Sequential fetch from reset.
        do_reset();
        check("rst_im_addr", 32'(bus.im_addr), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("seq_im_addr", 32'(bus.im_addr), 32'(k));
            check("seq_pc_d", bus.pc_d, PCB + 32'(4 * (k - 1)));
        end

        // Taken branch with negative offset, then not-taken.
        drive(NPC_BRANCH, 1'b1, 32'd0, 1'b0);
        tick();
        check("br_taken_addr", 32'(bus.im_addr), 32'd1);
        do_reset();
        for (int k = 0; k < 3; k++) tick();
        drive(NPC_BRANCH, 1'b0, 32'd0, 1'b0);
        tick();
        check("br_not_taken_addr", 32'(bus.im_addr), 32'd4);

        // Jump with delay slot.
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        check("j_pre_pc_d", bus.pc_d, 32'h3010);
        drive(NPC_JUMP, 1'b0, 32'd0, 1'b0);
        tick();
        check("j_slot_pc_d", bus.pc_d, 32'h3014);
        check("j_tgt_addr", 32'(bus.im_addr), 32'h10);

        // Stalled JREG resolves only once the stall clears.
        drive(NPC_JREG, 1'b0, 32'h3100, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_addr", 32'(bus.im_addr), 32'h10);
            check("stall_pc_d", bus.pc_d, 32'h3014);
        end
        bus.stall = 1'b0;
        tick();
        check("jreg_addr", 32'(bus.im_addr), 32'h40);
        check("jreg_pc_d", bus.pc_d, 32'h3040);

        // Reset during a stalled, pending branch.
        drive(NPC_BRANCH, 1'b1, 32'd0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        m_reset();
        check("arst_addr", 32'(bus.im_addr), 32'd0);
        check("arst_instr_d", bus.instr_d, 32'd0);
        check("arst_pc_d", bus.pc_d, PCB);
        tick();
        reset = 1'b0;
        drive(NPC_PC4, 1'b0, 32'd0, 1'b0);
        tick();
        check("arst_no_redirect", 32'(bus.im_addr), 32'd1);

        // Misaligned JREG target.
        drive(NPC_JREG, 1'b0, 32'h3002, 1'b0);
        tick();
        check("mis_addr", 32'(bus.im_addr), 32'd0);
        drive(NPC_PC4, 1'b0, 32'd0, 1'b0);
        tick();
`ifdef IFU_ADEL_EXC_EN
        check("adel_flag", 32'(bus.exc_adel_d), 32'd1);
        check("adel_nop", bus.instr_d, 32'd0);
`else
        check("mis_fetch", bus.instr_d, mem[0]);
`endif

        // Randomized traffic, including wraparound and occasional reset.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rs;
            case ($urandom_range(0, 3))
                0:       rs = $urandom;
                1:       rs = 32'hFFFF_FFFC;
                default: rs = PCB + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            drive(npc_op_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rs,
                  ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 49) == 0) begin
                #1;
                reset = 1'b1;
                #1;
                m_reset();
                compare_all();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter PC_BASE, default 32'h0000_3000, reset PC and base of instruction space.
REQ-002 Parameter IM_AW, default 11, instruction-memory word-address width (2048 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard stall from ID; holds PC and IF/ID register.
REQ-006 im_addr  output  IM_AW  word address to instruction memory.
REQ-007 im_ins  input  32  combinational instruction word returned for im_addr.
REQ-008 npc_op  input  2  next-PC select from ID: PC4, BRANCH, JUMP, JREG.
REQ-009 cmp_true  input  1  branch condition result from ID comparator.
REQ-010 rs_data  input  32  forwarded rs value for JREG.
REQ-011 instr_d  output  32  IF/ID registered instruction.
REQ-012 pc_d  output  32  IF/ID registered PC of instr_d.
REQ-013 pc8_d  output  32  pc_d + 8, link value for jal/jalr.

Function
REQ-014 The PC register SHALL drive im_addr = (pc - PC_BASE)[IM_AW+1:2]; upper/lower bits ignored.
REQ-015 The fetched word SHALL be im_ins in the same cycle (zero-latency read); IF/ID captures it at the next edge.
REQ-016 With stall=0, each edge SHALL load pc <= npc, instr_d <= im_ins, pc_d <= pc.
REQ-017 With stall=1, pc, instr_d, pc_d SHALL hold their values; npc_op/cmp_true are ignored that cycle.
REQ-018 npc SHALL be: PC4 -> pc+4; BRANCH -> cmp_true ? pc_d+4+(sext(instr_d[15:0])<<2) : pc+4; JUMP -> {pc_d[31:28], instr_d[25:0], 2'b00}; JREG -> rs_data.
REQ-019 Redirects SHALL take effect with one architectural delay slot: the instruction in IF when ID redirects is not flushed.
REQ-020 All PC arithmetic SHALL be 32-bit modulo 2^32 (wrap at 32'hFFFF_FFFC + 4 -> 0).
REQ-021 Branch immediate SHALL be sign-extended; negative offsets SHALL move the PC backward.
REQ-022 pc8_d SHALL be combinational pc_d + 8.

Reset
REQ-023 On reset assertion, asynchronously: pc <= PC_BASE, instr_d <= 0 (nop), pc_d <= PC_BASE.
REQ-024 Reset mid-stall or mid-redirect SHALL discard the pending redirect; first fetch after release is PC_BASE.
REQ-025 No output SHALL be X after reset; im_addr SHALL read 0 during reset.

Configuration
REQ-026 Macro IFU_ADEL_EXC_EN SHALL enable an extra output exc_adel_d (1 bit, registered with IF/ID).
REQ-027 With the macro: exc_adel_d=1 when fetched pc[1:0]!=0 or pc outside [PC_BASE, PC_BASE+4*2^IM_AW); that cycle instr_d SHALL be 0 (nop); reset value 0.
REQ-028 Without the macro: no exc_adel_d port; misaligned/out-of-range PC silently truncated per REQ-014.

Structure
REQ-029 Shared package SHALL hold npc_op encodings (PC4=0, BRANCH=1, JUMP=2, JREG=3) and the default PC_BASE constant.
REQ-030 Next-PC mux/adder SHALL be a combinational sub-module npc; PC and IF/ID registers stay in ifu.

Verification
REQ-031 Reset, release, 3 edges stall=0 npc_op=PC4 -> im_addr 0,1,2,3; pc_d 3000,3004,3008.
REQ-032 pc_d=3008, instr_d[15:0]=16'hFFFE, BRANCH, cmp_true=1 -> next pc 3004; cmp_true=0 -> pc+4.
REQ-033 pc_d=3010, instr_d[25:0]=26'h0000C10, JUMP -> pc 3040 after delay-slot fetch at 3014.
REQ-034 stall=1 for 2 cycles during JREG rs_data=3100 -> pc/instr_d frozen; after release pc=3100.
REQ-035 Assert reset while stall=1 and BRANCH pending -> pc=3000, instr_d=0 immediately, no redirect after release.
REQ-036 With IFU_ADEL_EXC_EN, JREG rs_data=3002 -> exc_adel_d=1, instr_d=0 next cycle; without macro im_addr=0.
